// File: rtl/gpio_input_stage_if.sv
// GPIO input stage bus: pad-side inputs, per-bit mode controls and sampled/status outputs.
// The register side holds the master modport; the input stage holds the slave modport.
interface gpio_input_stage_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_pad;
  logic             gpio_eclk;
  logic [WIDTH-1:0] eclk_en;
  logic [WIDTH-1:0] nec;
  logic [WIDTH-1:0] ptrig;
  logic [WIDTH-1:0] inte;
  logic             ie;
  logic [WIDTH-1:0] ints_clr;
  logic [WIDTH-1:0] rgpio_in;
  logic [WIDTH-1:0] rgpio_ints;
  logic             irq;

  modport master (
    output in_pad, gpio_eclk, eclk_en, nec, ptrig, inte, ie, ints_clr,
    input  rgpio_in, rgpio_ints, irq
  );

  modport slave (
    input  in_pad, gpio_eclk, eclk_en, nec, ptrig, inte, ie, ints_clr,
    output rgpio_in, rgpio_ints, irq
  );
endinterface

// File: rtl/gpio_input_stage.sv
// Synchronises GPIO pads, samples per bit on pclk or an external clock edge, and latches edge interrupts.
// Latency: pad to rgpio_in is SYNC_STAGES+1 pclk edges; no backpressure, status is sticky until cleared.
module gpio_input_stage #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic               pclk,
  input logic               presetn,
  gpio_input_stage_if.slave gpio
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0]       pad_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       pad_sync_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] eclk_sync_q, eclk_sync_d;
  logic                   eclk_dly_q, eclk_dly_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [WIDTH-1:0]       rgpio_in_q, rgpio_in_d;
  logic [WIDTH-1:0]       rgpio_ints_q, rgpio_ints_d;

  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] evt;
  logic             eclk_rise;
  logic             eclk_fall;
  logic             armed;

  always_comb begin
    pad_sync_d[0] = gpio.in_pad;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      pad_sync_d[k] = pad_sync_q[k-1];
    end
    eclk_sync_d = {eclk_sync_q[SYNC_STAGES-2:0], gpio.gpio_eclk};
    eclk_dly_d  = eclk_sync_q[SYNC_STAGES-1];

    sync_last = pad_sync_q[SYNC_STAGES-1];
    eclk_rise = eclk_sync_q[SYNC_STAGES-1] & ~eclk_dly_q;
    eclk_fall = ~eclk_sync_q[SYNC_STAGES-1] & eclk_dly_q;

    // Masks events until the reset-zero contents have flushed out of the pipeline.
    armed     = (arm_cnt_q == ARM_W'(ARM_MAX));
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);

    load = ~gpio.eclk_en
         | (gpio.nec & {WIDTH{eclk_fall}})
         | (~gpio.nec & {WIDTH{eclk_rise}});

    // Edge toward the ptrig polarity, seen only when the bit actually loads.
    evt = load & (sync_last ^ rgpio_in_q) & ~(sync_last ^ gpio.ptrig);

    rgpio_in_d   = (load & sync_last) | (~load & rgpio_in_q);
    rgpio_ints_d = (rgpio_ints_q & ~gpio.ints_clr)
                 | (evt & gpio.inte & {WIDTH{armed}});
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        pad_sync_q[k] <= '0;
      end
      eclk_sync_q  <= '0;
      eclk_dly_q   <= 1'b0;
      arm_cnt_q    <= '0;
      rgpio_in_q   <= '0;
      rgpio_ints_q <= '0;
    end else begin
      pad_sync_q   <= pad_sync_d;
      eclk_sync_q  <= eclk_sync_d;
      eclk_dly_q   <= eclk_dly_d;
      arm_cnt_q    <= arm_cnt_d;
      rgpio_in_q   <= rgpio_in_d;
      rgpio_ints_q <= rgpio_ints_d;
    end
  end

  assign gpio.rgpio_in   = rgpio_in_q;
  assign gpio.rgpio_ints = rgpio_ints_q;
  assign gpio.irq        = gpio.ie & (|rgpio_ints_q);

endmodule

// File: doc/gpio_input_stage.md
GPIO_INPUT_STAGE -- requirements
Module: gpio_input_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of GPIO lines.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, metastability synchronizer depth (legal 2..4).
REQ-003 SHALL have port pclk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port presetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_pad  input  WIDTH  raw pad input bus from the pad stage.
REQ-006 SHALL have port gpio_eclk  input  1  external sampling clock from the pad stage, asynchronous to pclk.
REQ-007 SHALL have port eclk_en  input  WIDTH  per bit: 1 = sample on gpio_eclk edge, 0 = sample every pclk.
REQ-008 SHALL have port nec  input  WIDTH  per bit: 1 = use falling gpio_eclk edge, 0 = rising.
REQ-009 SHALL have port ptrig  input  WIDTH  per bit: 1 = interrupt on 0->1 of rgpio_in, 0 = on 1->0.
REQ-010 SHALL have port inte  input  WIDTH  per-bit interrupt enable.
REQ-011 SHALL have port ie  input  1  global interrupt enable.
REQ-012 SHALL have port ints_clr  input  WIDTH  per-bit write-1-to-clear pulse for rgpio_ints, one pclk wide.
REQ-013 SHALL have port rgpio_in  output  WIDTH  registered sampled input value.
REQ-014 SHALL have port rgpio_ints  output  WIDTH  sticky per-bit interrupt status.
REQ-015 SHALL have port irq  output  1  interrupt request.

Function
REQ-016 SHALL pass in_pad through a SYNC_STAGES-deep flop chain per bit (sync_q = last stage).
REQ-017 SHALL pass gpio_eclk through a SYNC_STAGES-deep chain plus one delay flop; eclk_rise = sync & ~delay, eclk_fall = ~sync & delay, each one pclk wide.
REQ-018 SHALL load rgpio_in[i] <= sync_q[i] every cycle when eclk_en[i]=0.
REQ-019 SHALL load rgpio_in[i] <= sync_q[i] only in cycles with (nec[i] ? eclk_fall : eclk_rise) when eclk_en[i]=1; otherwise hold.
REQ-020 SHALL give latency, eclk_en=0: in_pad change stable before edge k appears on rgpio_in after edge k+SYNC_STAGES (3 edges for default).
REQ-021 SHALL define event[i] = load[i] & (sync_q[i] != rgpio_in[i]) & (ptrig[i] ? sync_q[i] : ~sync_q[i]).
REQ-022 SHALL set rgpio_ints[i] on the same edge that rgpio_in[i] updates when event[i] & inte[i] & armed.
REQ-023 SHALL clear rgpio_ints[i] when ints_clr[i]=1; simultaneous set and clear: set wins.
REQ-024 SHALL hold rgpio_ints[i] when inte[i] is deasserted; disabling does not clear status.
REQ-025 SHALL drive irq = ie & OR-reduce(rgpio_ints), combinational from registered state, no added latency.
REQ-026 SHALL implement an arm counter of width clog2(SYNC_STAGES+2): counts 0 to SYNC_STAGES+1 after reset release then saturates; armed = saturated; events are masked while not armed (prevents spurious interrupts from the reset-0 pipeline).
REQ-027 SHALL evaluate each bit independently; mixed eclk_en/nec/ptrig across bits are legal in the same cycle.
REQ-028 SHALL apply changes on eclk_en, nec, ptrig, inte from the next pclk edge; no event is synthesised by a mode change alone.

Reset
REQ-029 SHALL, while presetn=0, asynchronously force all synchronizer flops, eclk delay flop, rgpio_in, rgpio_ints and arm counter to 0; irq=0.
REQ-030 SHALL restart the arm counter from 0 on any reset, including reset asserted mid-operation.

Verification
REQ-031 SHALL verify: reset with in_pad=32'hFFFF_FFFF, inte=all 1, ptrig=all 1, ie=1, release -> rgpio_in=32'hFFFF_FFFF after 3 pclk, rgpio_ints stays 0, irq stays 0.
REQ-032 SHALL verify: armed, eclk_en=0, ptrig[0]=1, inte[0]=1, in_pad[0] 0->1 -> rgpio_in[0]=1 and rgpio_ints=32'h1 on edge 3, irq=1 same cycle.
REQ-033 SHALL verify: ints_clr=32'h1 one cycle -> rgpio_ints=0, irq=0 next edge; clear coinciding with new event on bit 0 -> rgpio_ints stays 32'h1.
REQ-034 SHALL verify: eclk_en=32'hFFFF_0000, nec=0, in_pad=32'hA5A5_A5A5, gpio_eclk held 0 -> rgpio_in=32'h0000_A5A5; after one gpio_eclk rising edge -> 32'hA5A5_A5A5 within SYNC_STAGES+2 pclk.
REQ-035 SHALL verify: nec[16]=1, eclk_en[16]=1 -> bit 16 updates only after gpio_eclk falling edge, not rising.
REQ-036 SHALL verify: ptrig[1]=0, inte[1]=1, ie=0, in_pad[1] 1->0 -> rgpio_ints[1]=1, irq=0; then ie=1 -> irq=1 next cycle.
